// File: rtl/alu_mc_if.sv
// -----------------------------------------------------------------------------
// alu_mc_if
// Handshake and data bundle for the multi-cycle ALU (alu_mc).
//
// Request side (master -> slave):
//   in_valid   request present
//   A, B       operands (B[SHW-1:0] doubles as the shift amount)
//   ALU_Sel    4-bit opcode
//   out_ready  consumer accepts the current result
// Response side (slave -> master):
//   in_ready   ALU can take a request this cycle
//   out_valid  ALU_Out and the flags are valid
//   ALU_Out    result
//   CarryOut, Zero, Negative, Overflow   status flags
// -----------------------------------------------------------------------------
interface alu_mc_if #(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALU_Sel;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALU_Out;
  logic             CarryOut;
  logic             Zero;
  logic             Negative;
  logic             Overflow;

  // Requester / result consumer side
  modport master (
    output in_valid, A, B, ALU_Sel, out_ready,
    input  in_ready, out_valid, ALU_Out, CarryOut, Zero, Negative, Overflow
  );

  // ALU side
  modport slave (
    input  in_valid, A, B, ALU_Sel, out_ready,
    output in_ready, out_valid, ALU_Out, CarryOut, Zero, Negative, Overflow
  );

endinterface

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Multi-cycle ALU with a valid/ready request port and a valid/ready result
// port. Logic and add/sub style operations finish one cycle after accept;
// shifts move one bit per cycle and multiply is an iterative shift-add that
// consumes one multiplier bit per cycle.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    alu_mc_if.slave: in_valid/in_ready, A, B, ALU_Sel,
//          out_valid/out_ready, ALU_Out, CarryOut, Zero, Negative, Overflow
//
// Parameters:
//   WIDTH  operand/result width (4..64)
//   SHW    shift-amount field width, derived from WIDTH
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic    clk,
  input  logic    reset,
  alu_mc_if.slave bus
);

  // Step counter must hold WIDTH itself for the multiply.
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOTA = 4'b0101;
  localparam logic [3:0] OP_NOTB = 4'b0110;
  localparam logic [3:0] OP_CLR  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t             state;
  logic               ready;
  logic               valid;
  logic [WIDTH-1:0]   result;
  logic               carry;
  logic               zero;
  logic               negative;
  logic               overflow;

  // Captured operation context for the iterative ops
  logic               op_mul;
  logic               op_left;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   sh_reg;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;

  // Combinational single-cycle datapath, evaluated on the live inputs
  logic [WIDTH:0]     add_full;
  logic [WIDTH-1:0]   diff;
  logic [SHW-1:0]     amt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_ovf;
  logic               needs_busy;

  // Iterative step values
  logic [WIDTH-1:0]   sh_next;
  logic               sh_bit;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   fin_res;
  logic               fin_carry;

  assign bus.in_ready  = ready;
  assign bus.out_valid = valid;
  assign bus.ALU_Out   = result;
  assign bus.CarryOut  = carry;
  assign bus.Zero      = zero;
  assign bus.Negative  = negative;
  assign bus.Overflow  = overflow;

  // Result of every op that completes straight from IDLE. Shifts by zero
  // land in the default branch, which passes A through with carry 0.
  always_comb begin
    add_full   = {1'b0, bus.A} + {1'b0, bus.B};
    diff       = bus.A - bus.B;
    amt        = bus.B[SHW-1:0];
    alu_res    = bus.A;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    case (bus.ALU_Sel)
      OP_ADD: begin
        alu_res   = add_full[WIDTH-1:0];
        alu_carry = add_full[WIDTH];
        // Same-sign operands producing a different-sign sum
        alu_ovf   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                    (add_full[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res   = diff;
        alu_carry = (bus.A < bus.B);
        // Opposite-sign operands where the difference takes B's sign
        alu_ovf   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                    (diff[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_AND:  alu_res = bus.A & bus.B;
      OP_OR:   alu_res = bus.A | bus.B;
      OP_XOR:  alu_res = bus.A ^ bus.B;
      OP_NOTA: alu_res = ~bus.A;
      OP_NOTB: alu_res = ~bus.B;
      OP_CLR:  alu_res = '0;
      default: alu_res = bus.A;
    endcase
    needs_busy = (bus.ALU_Sel == OP_MUL) ||
                 (((bus.ALU_Sel == OP_SHL) || (bus.ALU_Sel == OP_SHR)) &&
                  (amt != '0));
  end

  // One shift step or one shift-add step, plus the value that is published
  // when the final step is taken (so the last step's effect is included).
  always_comb begin
    sh_next  = op_left ? {sh_reg[WIDTH-2:0], 1'b0} : {1'b0, sh_reg[WIDTH-1:1]};
    sh_bit   = op_left ? sh_reg[WIDTH-1] : sh_reg[0];
    acc_next = acc + (mplier[0] ? mcand : '0);
    if (op_mul) begin
      fin_res   = acc_next[WIDTH-1:0];
      fin_carry = |acc_next[2*WIDTH-1:WIDTH];
    end else begin
      fin_res   = sh_next;
      fin_carry = sh_bit;
    end
  end

  // Control FSM and all registered outputs. Results are only written on the
  // transition into DONE, so ALU_Out and the flags keep the last result in
  // IDLE and BUSY, and an operation cut short by reset never publishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      valid    <= 1'b0;
      result   <= '0;
      carry    <= 1'b0;
      zero     <= 1'b0;
      negative <= 1'b0;
      overflow <= 1'b0;
      op_mul   <= 1'b0;
      op_left  <= 1'b0;
      cnt      <= '0;
      sh_reg   <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            ready <= 1'b0;
            if (needs_busy) begin
              state   <= BUSY;
              op_mul  <= (bus.ALU_Sel == OP_MUL);
              op_left <= (bus.ALU_Sel == OP_SHL);
              sh_reg  <= bus.A;
              acc     <= '0;
              mcand   <= {{WIDTH{1'b0}}, bus.A};
              mplier  <= bus.B;
              cnt     <= (bus.ALU_Sel == OP_MUL) ? CW'(WIDTH) : CW'(amt);
            end else begin
              state    <= DONE;
              valid    <= 1'b1;
              result   <= alu_res;
              carry    <= alu_carry;
              overflow <= alu_ovf;
              zero     <= (alu_res == '0);
              negative <= alu_res[WIDTH-1];
            end
          end
        end
        BUSY: begin
          if (op_mul) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end else begin
            sh_reg <= sh_next;
          end
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state    <= DONE;
            valid    <= 1'b1;
            result   <= fin_res;
            carry    <= fin_carry;
            overflow <= 1'b0;
            zero     <= (fin_res == '0);
            negative <= fin_res[WIDTH-1];
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state <= IDLE;
            valid <= 1'b0;
            ready <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          valid <= 1'b0;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc
// Scoreboard bench for alu_mc at WIDTH=16. The driver pushes the
// hand-computed response of each accepted request; a monitor pops and
// compares when out_valid rises, checks latency, and checks that the result
// and flags stay put while the consumer stalls.
// -----------------------------------------------------------------------------
module tb_alu_mc;

  localparam int W = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_NOTA = 4'b0101;
  localparam logic [3:0] OP_NOTB = 4'b0110;
  localparam logic [3:0] OP_CLR  = 4'b0111;
  localparam logic [3:0] OP_SHL  = 4'b1000;
  localparam logic [3:0] OP_SHR  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  typedef struct {
    int           id;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         n;
    logic         o;
    int           lat;
    int           acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   failures = 0;
  int   vec_id = 0;
  exp_t sb[$];

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request, wait (bounded) for it to be accepted, push the
  // expected response, then scramble the operands to prove they were captured.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] res, input logic c, input logic z,
                               input logic n, input logic o, input int lat,
                               input bit keep_valid, input bit expect_out);
    bit   accepted = 1'b0;
    bit   ready_seen;
    exp_t e;
    @(posedge clk);
    #1;
    bus.ALU_Sel  = op;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 400 && !accepted; i++) begin
      @(negedge clk);
      ready_seen = bus.in_ready;
      @(posedge clk);
      if (ready_seen) accepted = 1'b1;
    end
    #1;
    checkOutput($sformatf("t%0d_accept", vec_id), {63'd0, accepted}, 64'd1);
    if (accepted && expect_out) begin
      e.id  = vec_id;
      e.res = res;
      e.c   = c;
      e.z   = z;
      e.n   = n;
      e.o   = o;
      e.lat = lat;
      e.acc = cyc;
      sb.push_back(e);
    end
    vec_id++;
    bus.A = ~a;
    bus.B = ~b;
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  // Bounded wait for all expected results to be seen and the ALU to be idle
  task automatic waitIdle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.in_ready) done = 1'b1;
    end
    checkOutput(name, {63'd0, done}, 64'd1);
  endtask

  // Monitor: compare on the rising cycle of out_valid, then hold-check
  bit          seen = 1'b0;
  logic [19:0] snap;
  exp_t        cur;

  always @(negedge clk) begin
    if (reset) begin
      seen = 1'b0;
    end else if (bus.out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        snap = {bus.ALU_Out, bus.CarryOut, bus.Zero, bus.Negative, bus.Overflow};
        checkOutput("result_expected", {63'd0, (sb.size() != 0)}, 64'd1);
        if (sb.size() != 0) begin
          cur = sb.pop_front();
          checkOutput($sformatf("t%0d_latency", cur.id), 64'(cyc - cur.acc + 1), 64'(cur.lat));
          checkOutput($sformatf("t%0d_result", cur.id), 64'(bus.ALU_Out), 64'(cur.res));
          checkOutput($sformatf("t%0d_flags_czno", cur.id),
                      64'({bus.CarryOut, bus.Zero, bus.Negative, bus.Overflow}),
                      64'({cur.c, cur.z, cur.n, cur.o}));
        end
      end else begin
        checkOutput("hold_stable",
                    64'({bus.ALU_Out, bus.CarryOut, bus.Zero, bus.Negative, bus.Overflow}),
                    64'(snap));
      end
      checkOutput("in_ready_low_when_valid", {63'd0, bus.in_ready}, 64'd0);
      if (bus.out_ready) seen = 1'b0;
    end
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.A        = '0;
    bus.B        = '0;
    bus.ALU_Sel  = '0;

    repeat (3) @(negedge clk);
    checkOutput("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    checkOutput("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("reset_result", 64'(bus.ALU_Out), 64'd0);
    checkOutput("reset_flags", 64'({bus.CarryOut, bus.Zero, bus.Negative, bus.Overflow}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    //            op       A         B         result    C     Z     N     O    lat
    applyStimulus(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1);
    applyStimulus(OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1, 1,  1'b0, 1'b1);
    applyStimulus(OP_SHL,  16'h8001, 16'h0003, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b0, 4,  1'b0, 1'b1);
    applyStimulus(OP_MUL,  16'h0100, 16'h0101, 16'h0100, 1'b1, 1'b0, 1'b0, 1'b0, 17, 1'b0, 1'b1);
    applyStimulus(OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b1);
    applyStimulus(OP_SUB,  16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b1);
    applyStimulus(OP_SUB,  16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1);
    applyStimulus(OP_AND,  16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1);
    applyStimulus(OP_OR,   16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1);
    applyStimulus(OP_XOR,  16'hFFFF, 16'h00FF, 16'hFF00, 1'b0, 1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b1);
    applyStimulus(OP_NOTA, 16'h00FF, 16'h1111, 16'hFF00, 1'b0, 1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b1);
    applyStimulus(OP_NOTB, 16'h1234, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1);
    applyStimulus(OP_CLR,  16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1);
    applyStimulus(OP_SHR,  16'h8001, 16'h0001, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0, 2,  1'b0, 1'b1);
    applyStimulus(OP_SHL,  16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 1,  1'b0, 1'b1);
    applyStimulus(OP_SHR,  16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b1);
    applyStimulus(OP_SHL,  16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 16, 1'b0, 1'b1);
    applyStimulus(OP_MUL,  16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 17, 1'b0, 1'b1);
    applyStimulus(OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 17, 1'b0, 1'b1);
    applyStimulus(4'hB,    16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1,  1'b0, 1'b1);
    applyStimulus(4'hF,    16'hABCD, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b0, 1,  1'b0, 1'b1);
    waitIdle("idle_before_reset_test");

    // Reset in the fifth cycle of a multiply: nothing may be published
    applyStimulus(OP_MUL, 16'h0100, 16'h0101, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 17, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midreset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("midreset_result", 64'(bus.ALU_Out), 64'd0);
    checkOutput("midreset_flags", 64'({bus.CarryOut, bus.Zero, bus.Negative, bus.Overflow}), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      checkOutput("no_stale_valid", {63'd0, bus.out_valid}, 64'd0);
    end
    checkOutput("postreset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    checkOutput("postreset_result", 64'(bus.ALU_Out), 64'd0);

    applyStimulus(OP_ADD, 16'h0102, 16'h0304, 16'h0406, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    waitIdle("idle_before_backpressure");

    // Backpressure: consumer stalls 5 cycles while a new request is offered
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    applyStimulus(OP_ADD, 16'h1111, 16'h2222, 16'h3333, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      checkOutput("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      checkOutput("bp_result", 64'(bus.ALU_Out), 64'h3333);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("after_handshake_out_valid", {63'd0, bus.out_valid}, 64'd0);
    checkOutput("after_handshake_in_ready", {63'd0, bus.in_ready}, 64'd1);

    waitIdle("final_drain");
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
